// File: rtl/dm_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dm_responder: data-memory responder (req/ack, wait states, word RAM)     |
// | Optional: DM_BYTE_EN_EN adds be[3:0] byte-enabled stores.   Rev 1.0      |
// +--------------------------------------------------------------------------+
module dm_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DM_BYTE_EN_EN
  input  logic [3:0]  be,
`endif
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int          c_AW    = $clog2(DEPTH);
  localparam logic [32:0] c_LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [DEPTH];

  logic [3:0]      w_be_in;
  logic            w_capture;
  logic            w_commit;
  logic            w_a_we;
  logic [31:0]     w_a_addr;
  logic [31:0]     w_a_wdata;
  logic [3:0]      w_a_be;
  logic            w_a_err;
  logic [c_AW-1:0] w_idx;

`ifdef DM_BYTE_EN_EN
  assign w_be_in = be;
`else
  assign w_be_in = 4'hF;
`endif

  // With zero wait states the commit edge is the capture edge, so the access
  // fields come straight from the ports instead of the capture registers.
  assign w_capture = (r_state == S_IDLE) && req;
  assign w_commit  = (w_capture && (c_WAIT == 4'd0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_a_we    = w_capture ? we      : r_we;
  assign w_a_addr  = w_capture ? addr    : r_addr;
  assign w_a_wdata = w_capture ? wdata   : r_wdata;
  assign w_a_be    = w_capture ? w_be_in : r_be;
  assign w_idx     = w_a_addr[c_AW+1:2];

  // A store with no enabled byte is rejected; without byte enables be is all ones.
  assign w_a_err = (w_a_addr[1:0] != 2'b00) ||
                   ({1'b0, w_a_addr} >= c_LIMIT) ||
                   (w_a_we && (w_a_be == 4'b0000));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= w_be_in;
            r_cnt   <= c_WAIT;
            busy    <= 1'b1;
            r_state <= (c_WAIT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      if (w_commit) begin
        ack <= 1'b1;
        err <= w_a_err;
        if (!w_a_we && !w_a_err) begin
          rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // RAM is not reset; a reset edge must still block any commit.
  always_ff @(posedge clk) begin
    if (w_commit && w_a_we && !w_a_err && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_a_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_a_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dm_responder: randomized self-checking bench for dm_responder         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dm_responder;

  localparam int DEPTH = 16;
  localparam int W     = 2;
`ifdef DM_BYTE_EN_EN
  localparam bit USE_BE = 1'b1;
`else
  localparam bit USE_BE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  be_r = 4'hF;
  logic        ack, err, busy;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [3:0]  be0 = 4'hF;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DM_BYTE_EN_EN
    .be(be_r),
`endif
    .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef DM_BYTE_EN_EN
    .be(be0),
`endif
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  // Reference model: word array plus last successful load value.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata = 32'd0;

  task automatic model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, output bit e, output logic [31:0] rd);
    logic [3:0] bb;
    bb = USE_BE ? b : 4'hF;
    e  = (a % 4 != 0) || (longint'(a) >= longint'(4 * DEPTH)) || (w && bb == 4'h0);
    if (!e) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (bb[i]) m_mem[a / 4][8*i +: 8] = d[8*i +: 8];
      end else begin
        m_rdata = m_mem[a / 4];
      end
    end
    rd = m_rdata;
  endtask

  // Drives one transaction on u_dut, churns inputs after capture, reports timing.
  task automatic do_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int lat, output bit e,
                        output logic [31:0] rd, output bit busy_ok);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be_r = b;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be_r = 4'($urandom);
    lat = -1; e = 1'b0; rd = 32'd0; busy_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (ack) begin
        lat = k; e = err; rd = rdata;
        break;
      end
    end
    @(negedge clk);
    if (busy || ack) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, err, busy} !== 3'b000 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: ack/err/busy=%b rdata=%h, required 000 and 00000000", {ack, err, busy}, rdata);
    end
    checks++;
    if ({ack0, err0, busy0} !== 3'b000 || rdata0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_state_w0: ack/err/busy=%b rdata=%h, required 000 and 00000000", {ack0, err0, busy0}, rdata0);
    end
    rst = 1'b0;
  endtask

  task automatic test_init();
    int lat; bit e, ee, bok; logic [31:0] rd, erd, d;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model_apply(1'b1, 32'(4 * i), d, 4'hF, ee, erd);
      do_txn(1'b1, 32'(4 * i), d, 4'hF, lat, e, rd, bok);
      checks++;
      if (lat != W || e !== ee || !bok) begin
        failures++;
        $display("FAIL init_store[%0d]: lat=%0d err=%b busy_ok=%b, required lat=%0d err=%b busy_ok=1", i, lat, e, bok, W, ee);
      end
    end
  endtask

  task automatic test_store_load();
    int lat; bit e, ee, bok; logic [31:0] rd, erd;
    model_apply(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ee, erd);
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, e, rd, bok);
    checks++;
    if (lat != 2 || e !== 1'b0 || !bok) begin
      failures++;
      $display("FAIL store_0x10: lat=%0d err=%b busy_ok=%b, required lat=2 err=0 busy_ok=1", lat, e, bok);
    end
    model_apply(1'b0, 32'h10, 32'h0, 4'hF, ee, erd);
    do_txn(1'b0, 32'h10, 32'h0, 4'hF, lat, e, rd, bok);
    checks++;
    if (lat != 2 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_0x10: lat=%0d err=%b rdata=%h, required lat=2 err=0 rdata=deadbeef", lat, e, rd);
    end
  endtask

  task automatic test_errors();
    int lat; bit e, ee, bok; logic [31:0] rd, erd;
    model_apply(1'b1, 32'h14, 32'h12345678, 4'hF, ee, erd);
    do_txn(1'b1, 32'h14, 32'h12345678, 4'hF, lat, e, rd, bok);
    model_apply(1'b0, 32'h14, 32'h0, 4'hF, ee, erd);
    do_txn(1'b0, 32'h14, 32'h0, 4'hF, lat, e, rd, bok);
    checks++;
    if (rd !== 32'h12345678) begin
      failures++;
      $display("FAIL prior_load: rdata=%h, required 12345678", rd);
    end
    model_apply(1'b0, 32'h13, 32'h0, 4'hF, ee, erd);
    do_txn(1'b0, 32'h13, 32'h0, 4'hF, lat, e, rd, bok);
    checks++;
    if (lat != W || e !== 1'b1 || rd !== 32'h12345678 || !bok) begin
      failures++;
      $display("FAIL misaligned_load: lat=%0d err=%b rdata=%h busy_ok=%b, required lat=%0d err=1 rdata=12345678", lat, e, rd, bok, W);
    end
    model_apply(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, ee, erd);
    do_txn(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, lat, e, rd, bok);
    checks++;
    if (lat != W || e !== 1'b1) begin
      failures++;
      $display("FAIL oor_store: lat=%0d err=%b, required lat=%0d err=1", lat, e, W);
    end
    model_apply(1'b0, 32'h0, 32'h0, 4'hF, ee, erd);
    do_txn(1'b0, 32'h0, 32'h0, 4'hF, lat, e, rd, bok);
    checks++;
    if (e !== 1'b0 || rd !== erd) begin
      failures++;
      $display("FAIL ram0_after_oor: err=%b rdata=%h, required err=0 rdata=%h", e, rd, erd);
    end
  endtask

  task automatic test_churn();
    int lat; bit e, ee, bok; logic [31:0] rd, erd;
    model_apply(1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, ee, erd);
    do_txn(1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, lat, e, rd, bok);
    model_apply(1'b0, 32'h8, 32'h0, 4'hF, ee, erd);
    do_txn(1'b0, 32'h8, 32'h0, 4'hF, lat, e, rd, bok);
    checks++;
    if (e !== 1'b0 || rd !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL churn_load_0x8: err=%b rdata=%h, required err=0 rdata=a5a5a5a5", e, rd);
    end
  endtask

  task automatic test_reset_midop();
    int lat; bit e, ee, bok, saw_ack; logic [31:0] rd, erd;
    model_apply(1'b1, 32'hC, 32'h22222222, 4'hF, ee, erd);
    do_txn(1'b1, 32'hC, 32'h22222222, 4'hF, lat, e, rd, bok);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'hC; wdata = 32'h11111111; be_r = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ack !== 1'b0) begin
      failures++;
      $display("FAIL midop_wait: busy=%b ack=%b, required busy=1 ack=0", busy, ack);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL midop_reset: busy=%b ack=%b rdata=%h, required busy=0 ack=0 rdata=0", busy, ack, rdata);
    end
    saw_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack) saw_ack = 1'b1;
      if (k == 1) rst = 1'b0;
    end
    checks++;
    if (saw_ack) begin
      failures++;
      $display("FAIL midop_no_ack: ack seen=1, required 0");
    end
    m_rdata = 32'd0;
    model_apply(1'b0, 32'hC, 32'h0, 4'hF, ee, erd);
    do_txn(1'b0, 32'hC, 32'h0, 4'hF, lat, e, rd, bok);
    checks++;
    if (e !== 1'b0 || rd !== 32'h22222222) begin
      failures++;
      $display("FAIL midop_ram3: err=%b rdata=%h, required err=0 rdata=22222222", e, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [2];
    d[0] = $urandom; d[1] = $urandom;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = d[0]; be0 = 4'hF;
    for (int t = 0; t < 2; t++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b1 || busy0 !== 1'b1 || err0 !== 1'b0) begin
        failures++;
        $display("FAIL b2b_resp[%0d]: ack=%b busy=%b err=%b, required 1 1 0", t, ack0, busy0, err0);
      end
      addr0 = 32'h4; wdata0 = d[1];
      if (t == 1) req0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b0 || busy0 !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle[%0d]: ack=%b busy=%b, required 0 0", t, ack0, busy0);
      end
    end
    for (int t = 0; t < 2; t++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'(4 * t);
      @(posedge clk);
      @(negedge clk);
      req0 = 1'b0;
      checks++;
      if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== d[t]) begin
        failures++;
        $display("FAIL b2b_readback[%0d]: ack=%b err=%b rdata=%h, required 1 0 %h", t, ack0, err0, rdata0, d[t]);
      end
      @(negedge clk);
    end
  endtask

`ifdef DM_BYTE_EN_EN
  task automatic test_byte_en();
    int lat; bit e, ee, bok; logic [31:0] rd, erd;
    model_apply(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, ee, erd);
    do_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, lat, e, rd, bok);
    model_apply(1'b1, 32'h20, 32'h000000AB, 4'b0001, ee, erd);
    do_txn(1'b1, 32'h20, 32'h000000AB, 4'b0001, lat, e, rd, bok);
    model_apply(1'b0, 32'h20, 32'h0, 4'b0000, ee, erd);
    do_txn(1'b0, 32'h20, 32'h0, 4'b0000, lat, e, rd, bok);
    checks++;
    if (e !== 1'b0 || rd !== 32'hFFFFFFAB) begin
      failures++;
      $display("FAIL be_partial_load: err=%b rdata=%h, required err=0 rdata=ffffffab", e, rd);
    end
    model_apply(1'b1, 32'h20, 32'h12121212, 4'b0000, ee, erd);
    do_txn(1'b1, 32'h20, 32'h12121212, 4'b0000, lat, e, rd, bok);
    checks++;
    if (e !== 1'b1 || lat != W) begin
      failures++;
      $display("FAIL be_zero_store: err=%b lat=%0d, required err=1 lat=%0d", e, lat, W);
    end
  endtask
`endif

  task automatic test_random();
    int lat, sel; bit e, ee, bok, w; logic [31:0] rd, erd, a, d; logic [3:0] b;
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'(4 * DEPTH) + (32'($urandom_range(0, 100)) << 2);
      else               a = $urandom;
      w = 1'($urandom);
      d = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      model_apply(w, a, d, b, ee, erd);
      do_txn(w, a, d, b, lat, e, rd, bok);
      checks++;
      if (lat != W || e !== ee || rd !== erd || !bok) begin
        failures++;
        $display("FAIL random[%0d] we=%b addr=%h be=%h: lat=%0d err=%b rdata=%h busy_ok=%b, required lat=%0d err=%b rdata=%h busy_ok=1",
                 n, w, a, b, lat, e, rd, bok, W, ee, erd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_store_load();
    test_errors();
    test_churn();
    test_reset_midop();
    test_back_to_back();
`ifdef DM_BYTE_EN_EN
    test_byte_en();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
